// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial add/sub unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB
// so the top can derive signed overflow on the final digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  // Sum bit = a ^ b ^ cin at each position, so the MSB's carry-in falls out directly.
  assign c_msb_in = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/addsub_serial_unit.sv
// Digit-serial two's-complement add/sub, DIGIT bits per cycle, LSB digit first.
// Latency WIDTH/DIGIT+1 cycles accept-to-valid; holds result until out_ready, one op in flight.
// ADDSUB_SAT_EN: clamp result to the signed range on overflow (flags stay raw).
module addsub_serial_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] sum_d;
  logic             cout_d, c_msb_d, ovf_raw, last;
  logic [WIDTH-1:0] acc_next, res_fin;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .cin      (cy_q),
    .sum      (sum_d),
    .cout     (cout_d),
    .c_msb_in (c_msb_d)
  );

  // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));
  assign ovf_raw  = cout_d ^ c_msb_d;
  assign last     = (cnt_q == LAST);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = ~SMAX;

  // A wrapped-negative MSB on overflow means the true result was positive.
  always_comb begin
    res_fin = acc_next;
    if (ovf_raw) res_fin = acc_next[WIDTH-1] ? SMAX : SMIN;
  end
`else
  assign res_fin = acc_next;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b ^ {WIDTH{op}};
          cy_q  <= op;
          cnt_q <= '0;
        end
        CALC: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          acc_q <= acc_next;
          cy_q  <= cout_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            result   <= res_fin;
            carry    <= cout_d;
            overflow <= ovf_raw;
            zero     <= (res_fin == '0);
            negative <= res_fin[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Directed bench for addsub_serial_unit: 16/4 vector table, backpressure, mid-op reset,
// and the 16/16 and 8/1 geometries.
module tb_addsub_serial_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, op, out_ready, in_ready, out_valid;
  logic [15:0] a, b, result;
  logic        carry, overflow, zero, negative;

  logic        w_in_valid, w_op, w_out_ready, w_in_ready, w_out_valid;
  logic [15:0] w_a, w_b, w_result;
  logic        w_carry, w_overflow, w_zero, w_negative;

  logic        n_in_valid, n_op, n_out_ready, n_in_ready, n_out_valid;
  logic [7:0]  n_a, n_b, n_result;
  logic        n_carry, n_overflow, n_zero, n_negative;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  addsub_serial_unit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative));

  addsub_serial_unit #(.WIDTH(16), .DIGIT(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .carry(w_carry), .overflow(w_overflow), .zero(w_zero), .negative(w_negative));

  addsub_serial_unit #(.WIDTH(8), .DIGIT(1)) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
    .a(n_a), .b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result),
    .carry(n_carry), .overflow(n_overflow), .zero(n_zero), .negative(n_negative));

  typedef struct {
    logic        op;
    logic [15:0] a, b, res;
    logic        c, v, z, n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one op to the 16/4 unit, scramble inputs after accept, measure accept-to-valid cycles.
  task automatic run_main(input logic o, input logic [15:0] x, input logic [15:0] y, output int lat);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; a = 16'hDEAD; b = 16'hBEEF;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_main();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_w(input logic o, input logic [15:0] x, input logic [15:0] y, output int lat);
    w_in_valid = 1'b1; w_op = o; w_a = x; w_b = y;
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_a = 16'h0;
    lat = 1;
    while (!w_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_n(input logic o, input logic [7:0] x, input logic [7:0] y, output int lat);
    n_in_valid = 1'b1; n_op = o; n_a = x; n_b = y;
    @(posedge clk); #1;
    n_in_valid = 1'b0; n_a = 8'h0;
    lat = 1;
    while (!n_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ov_seen;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    vecs[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    vecs[6] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_op = 1'b0; w_a = '0; w_b = '0; w_out_ready = 1'b0;
    n_in_valid = 1'b0; n_op = 1'b0; n_a = '0; n_b = '0; n_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.in_ready", in_ready, 1'b1);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk16("rst.result", result, 16'h0000);
    chk1("rst.carry", carry, 1'b0);
    chk1("rst.overflow", overflow, 1'b0);
    chk1("rst.zero", zero, 1'b0);
    chk1("rst.negative", negative, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_main(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chki($sformatf("v%0d.latency", i), lat, 5);
      chk16($sformatf("v%0d.result", i), result, vecs[i].res);
      chk1($sformatf("v%0d.carry", i), carry, vecs[i].c);
      chk1($sformatf("v%0d.overflow", i), overflow, vecs[i].v);
      chk1($sformatf("v%0d.zero", i), zero, vecs[i].z);
      chk1($sformatf("v%0d.negative", i), negative, vecs[i].n);
      release_main();
      chk1($sformatf("v%0d.idle", i), in_ready, 1'b1);
    end

    // Backpressure: hold three cycles, offer a new operand while busy.
    run_main(1'b0, 16'h1111, 16'h2222, lat);
    chk16("bp.result0", result, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1); a = 16'hFFFF; b = 16'hFFFF;
      @(posedge clk); #1;
      chk16($sformatf("bp.result%0d", i + 1), result, 16'h3333);
      chk1($sformatf("bp.out_valid%0d", i + 1), out_valid, 1'b1);
      chk1($sformatf("bp.in_ready%0d", i + 1), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_main();
    chk1("bp.out_valid_drop", out_valid, 1'b0);
    chk1("bp.in_ready_back", in_ready, 1'b1);
    chk16("bp.result_kept", result, 16'h3333);

    // Reset during the second CALC cycle.
    in_valid = 1'b1; op = 1'b0; a = 16'h0005; b = 16'h0006;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("mrst.in_ready", in_ready, 1'b1);
    chk1("mrst.out_valid", out_valid, 1'b0);
    chk16("mrst.result", result, 16'h0000);
    chk1("mrst.carry", carry, 1'b0);
    chk1("mrst.zero", zero, 1'b0);
    ov_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chki("mrst.no_valid", ov_seen, 0);
    run_main(1'b0, 16'h0003, 16'h0004, lat);
    chki("mrst.latency", lat, 5);
    chk16("mrst.result_after", result, 16'h0007);
    release_main();

    // out_ready already high when the result appears: one-cycle valid.
    out_ready = 1'b1;
    run_main(1'b1, 16'h0009, 16'h0002, lat);
    chki("zw.latency", lat, 5);
    chk16("zw.result", result, 16'h0007);
    @(posedge clk); #1;
    chk1("zw.out_valid_drop", out_valid, 1'b0);
    chk1("zw.in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    // DIGIT = WIDTH = 16.
    run_w(1'b0, 16'hFFFF, 16'h0001, lat);
    chki("w.latency", lat, 2);
    chk16("w.result", w_result, 16'h0000);
    chk1("w.carry", w_carry, 1'b1);
    chk1("w.zero", w_zero, 1'b1);
    chk1("w.overflow", w_overflow, 1'b0);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    chk1("w.in_ready", w_in_ready, 1'b1);

    // DIGIT = 1, WIDTH = 8.
    run_n(1'b0, 8'hFF, 8'h01, lat);
    chki("n.latency", lat, 9);
    chk16("n.result", 16'(n_result), 16'h0000);
    chk1("n.carry", n_carry, 1'b1);
    chk1("n.zero", n_zero, 1'b1);
    chk1("n.overflow", n_overflow, 1'b0);
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0;
    run_n(1'b1, 8'h05, 8'h07, lat);
    chki("n.sub_latency", lat, 9);
    chk16("n.sub_result", 16'(n_result), 16'h00FE);
    chk1("n.sub_carry", n_carry, 1'b0);
    chk1("n.sub_negative", n_negative, 1'b1);
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_serial_unit.md
# addsub_serial_unit

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes and status flags. Operands of WIDTH bits are processed DIGIT bits per clock, LSB digit first, through a single DIGIT-bit ripple slice. Area scales with DIGIT rather than WIDTH. The block is the sequential successor to the team's 4-bit combinational add/sub stage and is the arithmetic core of the next-generation ALU datapath.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept operands.
- op  in  1  0 = add (a+b), 1 = subtract (a−b = a+~b+1).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- carry  out  1  carry-out of MSB; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- negative  out  1  result MSB.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b (b inverted when op=1), latch op, set carry register = op, clear digit counter, go to CALC.
- CALC:
  - Each cycle, add digit[cnt] of A and B' plus the carry register.
  - Write the sum digit into the result shift register; update the carry register.
  - Capture carry-into-MSB on the final digit for overflow (overflow = c_in_msb XOR c_out_msb).
  - After digit N−1 (N = WIDTH/DIGIT), go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready, go to IDLE.
- zero and negative are computed from the final result register, not from partial sums.
- Inputs a, b, op are sampled only at acceptance; later changes have no effect.
- in_valid while not in IDLE: ignored (in_ready=0); no stall, no corruption.
- Arithmetic wraps modulo 2^WIDTH unless saturation is compiled in (see Configuration).

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, carry=0, overflow=0, zero=0, negative=0, digit counter=0.
- Accept at edge k → digits processed at edges k+1..k+N → out_valid=1 after edge k+N. Latency N+1 cycles from accept to valid (5 for 16/4).
- out_valid stays high, with outputs stable, until the edge where out_ready=1. The earliest next accept is the edge after that, giving a throughput of one op per N+2 cycles.
- out_ready sampled high at the same edge out_valid rises: completes on that edge.
- rst asserted in any state (including mid-CALC): the next edge returns all registers to reset values; the partial result is discarded and no out_valid pulse occurs.
- DIGIT = WIDTH: N=1; single CALC cycle, latency 2.

## Configuration
- ADDSUB_SAT_EN defined: on signed overflow, result clamps to 2^(WIDTH−1)−1 when the true result is positive, −2^(WIDTH−1) when negative.
  - overflow still reports the raw overflow.
  - carry reports the raw carry.
  - zero/negative reflect the clamped result.
  - Clamping is applied on the CALC→DONE transition; latency unchanged.
- Undefined: wrap-around result; no clamp logic is synthesised.

## Structure
- Package addsub_pkg: state enum (IDLE, CALC, DONE), op encodings OP_ADD=0/OP_SUB=1, function computing N=WIDTH/DIGIT and counter width $clog2(N) (min 1).
- Sub-module addsub_digit: combinational DIGIT-bit ripple adder (a, b, cin → sum, cout, c_msb_in), instantiated once.
- Top holds the FSM, operand shift registers, carry register, counter, flag logic and the optional clamp.

## Test plan
- WIDTH=16, DIGIT=4, op=0, a=0x1234, b=0x4321 → result=0x5555, carry=0, overflow=0, zero=0, out_valid exactly 5 cycles after accept.
- op=0, a=0x7FFF, b=0x0001 → result=0x8000, overflow=1, negative=1, carry=0; with ADDSUB_SAT_EN → result=0x7FFF, overflow=1, negative=0.
- op=1, a=0x0000, b=0x0001 → result=0xFFFF, carry=0 (borrow), negative=1; op=1, a=b=0xABCD → result=0x0000, zero=1, carry=1.
- out_ready held low 3 cycles after out_valid → result/flags unchanged, in_ready=0; new in_valid with a=0xFFFF ignored; out_ready=1 → IDLE next cycle.
- rst pulsed on the 2nd CALC cycle → all outputs at reset values next cycle, no out_valid; subsequent op 0x0003+0x0004 → 0x0007 with normal latency.
- DIGIT=16, WIDTH=16 and DIGIT=1, WIDTH=8: 0xFF+0x01 (8-bit) → 0x00, carry=1, zero=1; latencies 2 and 9 cycles respectively.
